// File: rtl/float_acc_seq.sv
`timescale 1ns/1ps
// float_acc_seq: folds a variable-length packet of FP32 beats into one sum through
// a single shared external pipelined adder. A single-beat packet is output 2 cycles
// after it is accepted; an N-beat packet drains about ADD_LAT * log2(N) cycles after
// its last beat. in_ready is 1 only in ACCUM. Beats are never stalled while a packet
// is being accumulated. in_ready stays 0 while the block drains and until out_ready
// takes the sum.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   input beat stream; in_last marks the final beat
//   add_a/add_b/add_issue       combinational operands for the external adder
//   add_sum                     adder result, ADD_LAT cycles after the issue
//   out_valid/out_ready         packet sum handshake; out_data and out_count are registered
//   busy                        a packet is in progress, or operands are held or in flight
module float_acc_seq #(
  parameter int ADD_LAT = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_issue,
  input  logic [31:0]      add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_ACCUM = 2'd0,
    S_DRAIN = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_hold;
  logic               r_hold_v;
  logic [31:0]        w_hold_nxt;
  logic               w_hold_v_nxt;
  logic [ADD_LAT-1:0] r_vsr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_valid;
  logic [31:0]        r_out_data;
  logic [CNT_W-1:0]   r_out_count;
  logic               w_acc;
  logic               w_rv;
  logic               w_out_load;
  logic               w_out_done;

  assign in_ready  = (r_state == S_ACCUM);
  assign w_acc     = in_valid & in_ready;
  // The adder has no valid, so the valid shift register tells us when add_sum is real.
  assign w_rv      = r_vsr[ADD_LAT-1];
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign busy      = (r_state != S_ACCUM) | r_hold_v | (|r_vsr);

  // Pairing: any two available operands (hold, adder result, new beat) go to the
  // adder together. The fixed priority gives a deterministic operand order.
  always_comb begin
    w_hold_nxt   = r_hold;
    w_hold_v_nxt = r_hold_v;
    add_a        = 32'd0;
    add_b        = 32'd0;
    add_issue    = 1'b0;
    if (r_state != S_OUT) begin
      if (w_rv && r_hold_v) begin
        add_issue    = 1'b1;
        add_a        = r_hold;
        add_b        = add_sum;
        // The hold register is freed by this issue, so a new beat can take it at once.
        w_hold_v_nxt = w_acc;
        if (w_acc) w_hold_nxt = in_data;
      end else if (w_rv && w_acc) begin
        add_issue = 1'b1;
        add_a     = add_sum;
        add_b     = in_data;
      end else if (w_rv) begin
        w_hold_nxt   = add_sum;
        w_hold_v_nxt = 1'b1;
      end else if (r_hold_v && w_acc) begin
        add_issue    = 1'b1;
        add_a        = r_hold;
        add_b        = in_data;
        w_hold_v_nxt = 1'b0;
      end else if (w_acc) begin
        w_hold_nxt   = in_data;
        w_hold_v_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_out_load  = 1'b0;
    w_out_done  = 1'b0;
    case (r_state)
      S_ACCUM: if (w_acc && in_last) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        // Nothing is in flight and no result is arriving, so the hold register
        // contains the full packet sum.
        if ((r_vsr == '0) && !w_rv) begin
          w_state_nxt = S_OUT;
          w_out_load  = 1'b1;
        end
      end
      S_OUT: begin
        if (r_out_valid && out_ready) begin
          w_state_nxt = S_ACCUM;
          w_out_done  = 1'b1;
        end
      end
      default: w_state_nxt = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= 32'd0;
      r_hold_v    <= 1'b0;
      r_vsr       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 32'd0;
      r_out_count <= '0;
    end else begin
      r_hold   <= w_hold_nxt;
      r_hold_v <= w_out_load ? 1'b0 : w_hold_v_nxt;
      r_vsr[0] <= add_issue;
      for (int i = 1; i < ADD_LAT; i++) begin
        r_vsr[i] <= r_vsr[i-1];
      end
      if (w_out_done) begin
        r_cnt <= '0;
      end else if (w_acc && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_out_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_hold;
        r_out_count <= r_cnt;
      end else if (w_out_done) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/float_acc_seq.md
Name: float_acc_seq

Overview:
- Sequencer that reduces a variable-length packet of FP32 beats to a single sum using one shared, externally instantiated pipelined float `add` unit.
- Sits downstream of the float adder tree: each tree output is one beat, and this block folds successive beats together.
- It hides the adder latency by pairing any two available operands (held value, adder result, new input) without a stall.
- The adder carries no valid signal. This block tracks in-flight operations with an internal valid shift register.

Parameters:
- ADD_LAT, 3: fixed latency of the external adder in cycles, ≥1. A result presented at add_a/add_b in cycle t appears on add_sum in cycle t+ADD_LAT.
- CNT_W, 8: width of the beat counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat; equals (state==ACCUM)
- in_data  in  32  FP32 beat
- in_last  in  1  final beat of packet
- add_a  out  32  adder operand A (combinational)
- add_b  out  32  adder operand B (combinational)
- add_issue  out  1  operands valid this cycle (combinational)
- add_sum  in  32  adder result
- out_valid  out  1  packet sum valid (registered)
- out_ready  in  1  consumer accepts sum
- out_data  out  32  packet sum (registered)
- out_count  out  CNT_W  beats in packet, saturating at 2^CNT_W-1
- busy  out  1  state != ACCUM or hold valid or any in-flight bit set

Behaviour:
- Reset (async): state=ACCUM, hold_v=0, hold=0, vsr=0, out_valid=0, out_data=0, out_count=0, beat counter=0. in_ready therefore reads 1 while in reset.
- vsr[ADD_LAT-1:0]: vsr[0]<=add_issue and vsr[i]<=vsr[i-1]. r_v=vsr[ADD_LAT-1], and r=add_sum.
- Accept: acc = in_valid & in_ready.
- Pairing rules, evaluated every cycle in ACCUM and DRAIN, first match wins:
  1. r_v & hold_v: issue(a=hold, b=r), then hold_v<=0. If acc, hold<=in_data and hold_v<=1.
  2. r_v & !hold_v & acc: issue(a=r, b=in_data).
  3. r_v & !hold_v & !acc: hold<=r, hold_v<=1.
  4. !r_v & hold_v & acc: issue(a=hold, b=in_data), then hold_v<=0.
  5. !r_v & !hold_v & acc: hold<=in_data, hold_v<=1.
  6. Otherwise: no change. add_a, add_b and add_issue are 0.
- The operand order is fixed by these rules, so the FP rounding result is deterministic.
- No input stall ever occurs in ACCUM.
- Beat counter increments on acc and saturates. It clears on the out handshake.
- FSM:
  - ACCUM: on acc & in_last, go to DRAIN.
  - DRAIN: in_ready=0 and the pairing rules continue. When vsr==0 (registered value) and !r_v, go to OUT with out_data<=hold, out_valid<=1, out_count<=counter, hold_v<=0. hold_v is guaranteed 1 here.
  - OUT: out_valid held and out_data stable until out_ready. On out_valid & out_ready: out_valid<=0, counter<=0, go to ACCUM.
- The next packet's first beat can be accepted in the cycle after the handshake.
- Single-beat packet: the beat passes through unchanged, with no add issued.
- in_last with in_valid=0 is ignored.
- No out_ready backpressure is visible on the input side other than in_ready=0.
- Reset mid-packet discards hold, vsr and the partial sum. Stale add_sum values are ignored because vsr=0.
- Data values are not interpreted. NaN and Inf propagate through the adder only.

Test Plan:
- ADD_LAT=3, beats 1.0, 2.0, 3.0, 4.0 (0x3F800000, 0x40000000, 0x40400000, 0x40800000) back-to-back, last on the 4th beat, out_ready=1. Expect:
  - issues in cycles 1, 3 and 6;
  - out_valid in cycle 11 with out_data=0x41200000 and out_count=4;
  - in_ready=0 during cycles 4–11.
- Single beat 0xC0A00000 (-5.0) with in_last, ADD_LAT=3 → no add_issue; out_data=0xC0A00000 with out_valid 2 cycles after accept; out_count=1.
- 8 beats of 1.0 with in_valid toggling every other cycle, ADD_LAT=1 → out_data=0x41000000 and out_count=8; no beat is lost.
- out_ready held 0 for 5 cycles in OUT → out_valid and out_data stable and in_ready=0 throughout. After the handshake, in_ready=1 in the next cycle and the next packet {2.0, 2.0} yields 0x40800000.
- Assert rst_n low with 2 adds in flight mid-packet → all outputs return to reset values immediately. The next packet {1.0, 1.0} yields 0x40000000, unaffected by stale add_sum.
- 300 beats of 0.0 with CNT_W=8 → out_count=255 (saturated) and out_data=0x00000000.
